// File: rtl/mux153_pkg.sv
// mux153_pkg: shared encodings for the '153 round-robin scheduler (SEL_W, NREQ, FSM states)
package mux153_pkg;
  localparam int SEL_W = 2;
  localparam int NREQ = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick; ports req[3:0], last[1:0] -> winner[1:0], valid
module rr_pick4
  import mux153_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             valid
);
  logic [NREQ-1:0] rot;
  // rot[i] is the request at position (last+1+i) mod 4, so the lowest set bit wins
  assign rot = NREQ'({req, req} >> ({1'b0, last} + 3'd1));
  assign winner = rot[0] ? last + 2'd1 : rot[1] ? last + 2'd2 : rot[2] ? last + 2'd3 : last;
  assign valid = |req;
endmodule

// File: rtl/mux153_rr_sched.sv
// mux153_rr_sched: round-robin scheduler driving a shared dual 4-to-1 '153 mux
// Ports: i_clk, i_rst (sync, active-high), i_req[3:0], i_ch_en[1:0],
//   o_gnt[3:0] one-hot grant, o_B/o_A select, o_1G/o_2G active-low strobes, o_busy.
// MUX153_SCHED_LOCK_EN adds i_lock, which suspends the BURST_MAX limit while in GRANT.
module mux153_rr_sched
  import mux153_pkg::*;
#(
  parameter int BURST_MAX = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_ch_en,
`ifdef MUX153_SCHED_LOCK_EN
  input  logic            i_lock,
`endif
  output logic [NREQ-1:0] o_gnt,
  output logic            o_B,
  output logic            o_A,
  output logic            o_1G,
  output logic            o_2G,
  output logic            o_busy
);
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  logic [1:0] st_q, st_d, en_q, en_d;
  logic [SEL_W-1:0] own_q, own_d, last_q, last_d, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q;
  logic g1_q, g2_q, busy_q, vld, lock, done;
  rr_pick4 u_pick (.req(i_req), .last(last_q), .winner(win), .valid(vld));
`ifdef MUX153_SCHED_LOCK_EN
  assign lock = i_lock;
`else
  assign lock = 1'b0;
`endif
  assign done = !i_req[own_q] || (cnt_q == CNT_MAX && !lock);
  // IDLE and GAP share the arbitration path; last_q is updated on GRANT->GAP so the GAP picks past the old owner
  always_comb begin
    st_d = st_q;
    own_d = own_q;
    last_d = last_q;
    cnt_d = cnt_q;
    en_d = en_q;
    if (st_q == ST_GRANT) begin
      st_d = done ? ST_GAP : ST_GRANT;
      last_d = done ? own_q : last_q;
      cnt_d = (done || cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end else if (vld) begin
      st_d = ST_GRANT;
      own_d = win;
      cnt_d = CNT_W'(1);
      en_d = i_ch_en;
    end else begin
      st_d = ST_IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q <= ST_IDLE;
      own_q <= '0;
      last_q <= 2'd3;
      cnt_q <= '0;
      en_q <= '0;
      gnt_q <= '0;
      g1_q <= 1'b1;
      g2_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      own_q <= own_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      gnt_q <= (st_d == ST_GRANT) ? NREQ'(1) << own_d : '0;
      g1_q <= !(st_d == ST_GRANT && en_d[0]);
      g2_q <= !(st_d == ST_GRANT && en_d[1]);
      busy_q <= st_d != ST_IDLE;
    end
  end
  assign o_gnt = gnt_q;
  assign {o_B, o_A} = own_q;
  assign o_1G = g1_q;
  assign o_2G = g2_q;
  assign o_busy = busy_q;
endmodule
